gost_gamma_ctrl: RTL

- Sequencer that runs the GOST 28147-89 block core in gamma (counter) mode.
- Encrypts the synchro-message (IV) once, then steps the N3/N4 counter with C2/C1 for each block.
- Encrypts each counter value to get 64-bit gamma, and XORs the gamma into a valid/ready data stream.
- Sits between the stream fabric and one gost_28147_89 instance; drives the core's load/mode/pdata and consumes done/cdata. Key is wired to the core externally and held stable while busy.

---
 rtl/gost_gamma_ctrl_pkg.sv | 27 ++
 rtl/gost_add_mod32m1.sv | 17 +
 rtl/gost_gamma_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/gost_gamma_ctrl_pkg.sv
// Shared constants, state encoding and word-order helpers for the
// GOST 28147-89 gamma-mode sequencer.
package gost_gamma_ctrl_pkg;

  localparam logic [31:0] C1 = 32'h0101_0104;
  localparam logic [31:0] C2 = 32'h0101_0101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IV_LD = 3'd1,
    ST_IV_WT = 3'd2,
    ST_CT_LD = 3'd3,
    ST_CT_WT = 3'd4,
    ST_XOR   = 3'd5,
    ST_LAST  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

  function automatic logic [31:0] word_hi(input logic [63:0] blk);
    return blk[63:32];
  endfunction

  function automatic logic [31:0] word_lo(input logic [63:0] blk);
    return blk[31:0];
  endfunction

endpackage

// File: rtl/gost_add_mod32m1.sv
// Combinational 32-bit adder with end-around carry (addition mod 2^32-1);
// 0xFFFFFFFF is left as-is rather than folded to zero.
module gost_add_mod32m1 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic [32:0] s;

  // Plain 33-bit add, then feed the carry back into bit 0.
  always_comb begin
    s   = {1'b0, a} + {1'b0, b};
    sum = s[31:0] + {31'd0, s[32]};
  end

endmodule

// File: rtl/gost_gamma_ctrl.sv
// Gamma (counter) mode sequencer for one GOST 28147-89 block core:
// encrypts the IV once, steps N3/N4 per block and XORs gamma into the stream.
module gost_gamma_ctrl
  import gost_gamma_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] iv,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic        core_mode,
  output logic        core_load,
  output logic [63:0] core_pdata,
  input  logic        core_done,
  input  logic [63:0] core_cdata,
  output logic        busy,
  output logic        err,
  output logic        msg_done
);

  localparam int TCW = $clog2(TIMEOUT + 1);

  state_t         state;
  state_t         state_nx;
  logic [31:0]    cnt_a;
  logic [31:0]    cnt_b;
  logic [31:0]    a_nx;
  logic [31:0]    b_nx;
  logic [31:0]    add_x;
  logic [31:0]    add_sum;
  logic [63:0]    gamma;
  logic           g_valid;
  logic [TCW-1:0] tcnt;
  logic           tmo;
  logic           in_hs;

  assign core_mode = 1'b0;
  // Gating with abort keeps a beat from being accepted in the cycle it is discarded.
  assign in_ready  = g_valid & (~out_valid | out_ready) & ~abort;
  assign in_hs     = in_valid & in_ready;
  // The load cycle counts toward the limit, so the wait phase gets TIMEOUT-1 cycles.
  assign tmo       = (tcnt == TCW'(TIMEOUT - 2));
  assign add_x     = (state == ST_IV_WT) ? word_hi(core_cdata) : cnt_b;

  gost_add_mod32m1 u_add (
    .a   (add_x),
    .b   (C1),
    .sum (add_sum)
  );

  // Next state and next counter values.
  always_comb begin
    state_nx = state;
    a_nx     = cnt_a;
    b_nx     = cnt_b;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nx = ST_IV_LD; else state_nx = ST_IDLE;
        ST_IV_LD: state_nx = ST_IV_WT;
        ST_IV_WT: begin
          if (core_done) begin
            state_nx = ST_CT_LD;
            a_nx     = word_lo(core_cdata) + C2;
            b_nx     = add_sum;
          end else if (tmo) begin
            state_nx = ST_ERR;
          end else begin
            state_nx = ST_IV_WT;
          end
        end
        ST_CT_LD: state_nx = ST_CT_WT;
        ST_CT_WT: begin
          if (core_done)  state_nx = ST_XOR;
          else if (tmo)   state_nx = ST_ERR;
          else            state_nx = ST_CT_WT;
        end
        ST_XOR: begin
          if (in_hs && in_last) begin
            state_nx = ST_LAST;
          end else if (in_hs) begin
            state_nx = ST_CT_LD;
            a_nx     = cnt_a + C2;
            b_nx     = add_sum;
          end else begin
            state_nx = ST_XOR;
          end
        end
        ST_LAST:  state_nx = ST_IDLE;
        ST_ERR:   state_nx = ST_ERR;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Counters, gamma, output beat and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_a      <= 32'd0;
      cnt_b      <= 32'd0;
      gamma      <= 64'd0;
      g_valid    <= 1'b0;
      tcnt       <= {TCW{1'b0}};
      core_load  <= 1'b0;
      core_pdata <= 64'd0;
      out_valid  <= 1'b0;
      out_data   <= 64'd0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      msg_done   <= 1'b0;
    end else begin
      cnt_a     <= a_nx;
      cnt_b     <= b_nx;
      tcnt      <= (state == ST_IV_WT || state == ST_CT_WT) ? tcnt + TCW'(1) : {TCW{1'b0}};
      core_load <= (state_nx == ST_IV_LD) || (state_nx == ST_CT_LD);
      busy      <= (state_nx != ST_IDLE) && (state_nx != ST_ERR);
      err       <= (state_nx == ST_ERR);
      msg_done  <= (state_nx == ST_LAST);
      if (state_nx == ST_IV_LD)      core_pdata <= iv;
      else if (state_nx == ST_CT_LD) core_pdata <= {b_nx, a_nx};
      if (state_nx == ST_XOR && state == ST_CT_WT) gamma <= core_cdata;
      if (abort)                                   g_valid <= 1'b0;
      else if (state == ST_CT_WT && core_done)     g_valid <= 1'b1;
      else if (in_hs)                              g_valid <= 1'b0;
      if (in_hs) begin
        out_data  <= in_data ^ gamma;
        out_last  <= in_last;
        out_valid <= 1'b1;
      end else if (abort || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
